// File: rtl/clk_lock_monitor.sv
// rtl/clk_lock_monitor.sv - clk_in period and lock monitor on clk_ref; CLK_LOCK_MONITOR_TIMEOUT_EN adds stall timeout
module clk_lock_monitor #(
    parameter int CNT_W         = 16,
    parameter int EXPECT_PERIOD = 32,
    parameter int TOL           = 1,
    parameter int LOCK_COUNT    = 4
) (
    input  logic             clk_ref,
    input  logic             rst_n,
    input  logic             clk_in,
    input  logic             enable,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             locked,
    output logic             lost,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2,
        LOST    = 2'd3
    } state_t;

    localparam int              GC_W    = $clog2(LOCK_COUNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W:0]   EXP_EXT = (CNT_W + 1)'(EXPECT_PERIOD);
    localparam logic [CNT_W:0]   TOL_EXT = (CNT_W + 1)'(TOL);
    localparam logic [GC_W-1:0]  GC_LOCK = GC_W'(LOCK_COUNT);

    state_t           st;
    logic             sync1;
    logic             sync2;
    logic             hist;
    logic [CNT_W-1:0] cnt;
    logic [GC_W-1:0]  good_cnt;
    logic             armed;
    logic             rise_det;
    logic             fall_det;
    logic [CNT_W:0]   dev;
    logic             good;
    logic             timeout;

    assign state    = st;
    assign rise_det = sync2 & ~hist;
    assign fall_det = ~sync2 & hist;

    // A saturated count means the real interval is unknown, so it never qualifies.
    always_comb begin
        dev  = '0;
        good = 1'b0;
        if ({1'b0, cnt} >= EXP_EXT) begin
            dev = {1'b0, cnt} - EXP_EXT;
        end else begin
            dev = EXP_EXT - {1'b0, cnt};
        end
        good = (dev <= TOL_EXT) && (cnt != CNT_MAX);
    end

`ifdef CLK_LOCK_MONITOR_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TMO_CNT = CNT_W'(2 * EXPECT_PERIOD);
    assign timeout = ((st == ACQUIRE) || (st == LOCKED)) && (cnt == TMO_CNT) && !rise_det;
`else
    assign timeout = 1'b0;
`endif

    // clk_in is asynchronous data; only sync2/hist feed edge detection.
    always_ff @(posedge clk_ref) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            hist  <= 1'b0;
        end else begin
            sync1 <= clk_in;
            sync2 <= sync1;
            hist  <= sync2;
        end
    end

    always_ff @(posedge clk_ref) begin
        if (!rst_n || !enable) begin
            st           <= IDLE;
            cnt          <= '0;
            good_cnt     <= '0;
            armed        <= 1'b0;
            period       <= '0;
            period_valid <= 1'b0;
            rise_pulse   <= 1'b0;
            fall_pulse   <= 1'b0;
            locked       <= 1'b0;
            lost         <= 1'b0;
        end else begin
            rise_pulse   <= rise_det;
            fall_pulse   <= fall_det;
            period_valid <= 1'b0;

            // The first rise after reset/enable only starts the interval.
            if (rise_det) begin
                cnt   <= CNT_W'(1);
                armed <= 1'b1;
                if (armed) begin
                    period       <= cnt;
                    period_valid <= 1'b1;
                end
            end else if (timeout) begin
                cnt <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end

            case (st)
                IDLE: begin
                    st       <= ACQUIRE;
                    good_cnt <= '0;
                end
                ACQUIRE: begin
                    if (good_cnt == GC_LOCK) begin
                        st     <= LOCKED;
                        locked <= 1'b1;
                    end else if (rise_det && armed) begin
                        good_cnt <= good ? good_cnt + 1'b1 : '0;
                    end else if (timeout) begin
                        st   <= LOST;
                        lost <= 1'b1;
                    end
                end
                LOCKED: begin
                    if ((rise_det && armed && !good) || timeout) begin
                        st     <= LOST;
                        locked <= 1'b0;
                        lost   <= 1'b1;
                    end
                end
                LOST: begin
                    if (rise_det) begin
                        st       <= ACQUIRE;
                        good_cnt <= '0;
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_clk_lock_monitor.sv
// tb/tb_clk_lock_monitor.sv - scoreboard bench for clk_lock_monitor
module tb_clk_lock_monitor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clk_in;
    logic        enable;
    logic        rise_pulse;
    logic        fall_pulse;
    logic [15:0] period;
    logic        period_valid;
    logic        locked;
    logic        lost;
    logic [1:0]  state;

    clk_lock_monitor dut (
        .clk_ref      (clk),
        .rst_n        (rst_n),
        .clk_in       (clk_in),
        .enable       (enable),
        .rise_pulse   (rise_pulse),
        .fall_pulse   (fall_pulse),
        .period       (period),
        .period_valid (period_valid),
        .locked       (locked),
        .lost         (lost),
        .state        (state)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_q[$];
    logic [15:0] exp_p;
    int          cyc = 0;
    int          last_rise_cyc = 0;
    int          last_pv_cyc = 0;
    int          lock_cyc = 0;
    int          lost_cyc = 0;
    int          falls_driven = 0;
    int          falls_seen = 0;
    logic        prev_locked = 1'b0;
    logic [1:0]  prev_state = 2'd0;
    bit          armed_m = 1'b0;
    int          last_len = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pops the scoreboard whenever the DUT strobes a period.
    always @(negedge clk) begin
        if (rise_pulse) last_rise_cyc = cyc;
        if (fall_pulse) falls_seen++;
        if (locked && !prev_locked) lock_cyc = cyc;
        if (state == 2'd3 && prev_state != 2'd3) lost_cyc = cyc;
        prev_locked = locked;
        prev_state  = state;
        if (period_valid) begin
            last_pv_cyc = cyc;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL period_unexpected got=%0d want=no strobe", period);
            end else begin
                exp_p = exp_q.pop_front();
                if (period !== exp_p) begin
                    errors++;
                    $display("FAIL period got=%0d want=%0d", period, exp_p);
                end
            end
            checks++;
            if (rise_pulse !== 1'b1) begin
                errors++;
                $display("FAIL pv_rise_align got=%0b want=1", rise_pulse);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_state"}, 32'(state), 0);
        chk({tag, "_locked"}, 32'(locked), 0);
        chk({tag, "_lost"}, 32'(lost), 0);
        chk({tag, "_period"}, 32'(period), 0);
        chk({tag, "_pv"}, 32'(period_valid), 0);
        chk({tag, "_rise"}, 32'(rise_pulse), 0);
    endtask

    // One clk_in period: rise, hi cycles high, lo cycles low.
    task automatic per(input int hi, input int lo);
        @(negedge clk);
        clk_in = 1'b1;
        if (armed_m) exp_q.push_back(last_len > 65535 ? 16'hFFFF : 16'(last_len));
        armed_m  = 1'b1;
        last_len = hi + lo;
        repeat (hi - 1) @(negedge clk);
        @(negedge clk);
        clk_in = 1'b0;
        falls_driven++;
        repeat (lo - 1) @(negedge clk);
    endtask

    initial begin
        rst_n  = 1'b0;
        enable = 1'b0;
        clk_in = 1'b0;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        chk("reset_fall", 32'(fall_pulse), 0);
        rst_n  = 1'b1;
        enable = 1'b1;
        repeat (2) @(negedge clk);
        chk("acquire_entry", 32'(state), 1);

        // First rise: arms only; pulse latency is three clk_ref edges.
        @(negedge clk);
        clk_in   = 1'b1;
        armed_m  = 1'b1;
        last_len = 32;
        @(negedge clk);
        chk("rise_lat1", 32'(rise_pulse), 0);
        @(negedge clk);
        chk("rise_lat2", 32'(rise_pulse), 0);
        @(negedge clk);
        chk("rise_lat3", 32'(rise_pulse), 1);
        @(negedge clk);
        chk("rise_width", 32'(rise_pulse), 0);
        repeat (12) @(negedge clk);
        clk_in = 1'b0;
        falls_driven++;
        repeat (15) @(negedge clk);

        // Nominal lock
        repeat (3) per(16, 16);
        chk("acq_3good", 32'(state), 1);
        per(16, 16);
        chk("lock_state", 32'(state), 2);
        chk("lock_flag", 32'(locked), 1);
        chk("lock_lost0", 32'(lost), 0);
        chk("lock_latency", 32'(lock_cyc - last_pv_cyc), 1);

        // Stretched half-period gives 36 -> LOST, then relock
        per(20, 16);
        per(16, 16);
        chk("lost_state", 32'(state), 3);
        chk("lost_flag", 32'(lost), 1);
        chk("lost_locked0", 32'(locked), 0);
        per(16, 16);
        repeat (3) per(16, 16);
        chk("relock_pending", 32'(state), 1);
        per(16, 16);
        chk("relock_state", 32'(state), 2);
        chk("relock_lost1", 32'(lost), 1);

        // Enable low for one cycle coinciding with a rise event
        @(negedge clk);
        clk_in  = 1'b1;
        armed_m = 1'b0;
        repeat (2) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        chk_zero("en_low");
        enable = 1'b1;
        repeat (12) @(negedge clk);
        clk_in = 1'b0;
        falls_driven++;
        repeat (15) @(negedge clk);

        // Arm, 32, 32, 34 (bad), then 33, 31, 33, 31 within tolerance
        per(16, 16);
        per(16, 16);
        per(17, 17);
        per(17, 16);
        per(16, 15);
        per(17, 16);
        per(16, 15);
        chk("tol_pending", 32'(state), 1);
        per(16, 16);
        chk("tol_lock", 32'(state), 2);

        // Stalled clk_in while locked
`ifdef CLK_LOCK_MONITOR_TIMEOUT_EN
        per(16, 100);
        chk("tmo_state", 32'(state), 3);
        chk("tmo_lost", 32'(lost), 1);
        chk("tmo_delay", 32'(lost_cyc - last_rise_cyc), 64);
        last_len = 116 - 65;
`else
        per(16, 65600);
        chk("stall_locked", 32'(state), 2);
        chk("stall_lost0", 32'(lost), 0);
`endif
        per(16, 16);
        chk("stall_exit", 32'(state), 3);
        chk("stall_lost", 32'(lost), 1);

        // Reset mid-ACQUIRE
        per(16, 16);
        chk("pre_rst_acq", 32'(state), 1);
        @(negedge clk);
        clk_in = 1'b1;
        exp_q.push_back(16'(last_len));
        repeat (15) @(negedge clk);
        @(negedge clk);
        clk_in = 1'b0;
        falls_driven++;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk_zero("mid_rst");
        rst_n   = 1'b1;
        armed_m = 1'b0;
        repeat (9) @(negedge clk);
        per(16, 16);
        per(16, 16);
        per(16, 16);
        repeat (10) @(negedge clk);

        chk("queue_drained", 32'(exp_q.size()), 0);
        chk("fall_count", 32'(falls_seen), 32'(falls_driven));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/clk_lock_monitor.md
CLK_LOCK_MONITOR -- requirements
Module: clk_lock_monitor

Interface
REQ-001 Parameter CNT_W, default 16: width of the period counter and the period output.
REQ-002 Parameter EXPECT_PERIOD, default 32: nominal clk_in period in clk_ref cycles (divide-by-16 toggle gives 32).
REQ-003 Parameter TOL, default 1: allowed absolute deviation from EXPECT_PERIOD, in cycles.
REQ-004 Parameter LOCK_COUNT, default 4: consecutive good periods needed to declare lock.
REQ-005 clk_ref  in  1  sole clock; all logic on the rising edge.
REQ-006 rst_n  in  1  synchronous, active-low reset.
REQ-007 clk_in  in  1  divided clock from the upstream divider, treated as asynchronous data, never used as a clock.
REQ-008 enable  in  1  monitor enable; low forces IDLE.
REQ-009 rise_pulse  out  1  one-cycle pulse per detected clk_in rising edge.
REQ-010 fall_pulse  out  1  one-cycle pulse per detected clk_in falling edge.
REQ-011 period  out  CNT_W  last measured rise-to-rise interval.
REQ-012 period_valid  out  1  one-cycle strobe when period updates.
REQ-013 locked  out  1  high only in state LOCKED.
REQ-014 lost  out  1  sticky flag: lock lost since last reset or enable low.
REQ-015 state  out  2  IDLE=0, ACQUIRE=1, LOCKED=2, LOST=3.

Function
REQ-016 clk_in SHALL pass through a 2-flop synchronizer plus one history flop; edge detection SHALL use only synchronized values.
REQ-017 rise_pulse/fall_pulse SHALL be registered and rise exactly 3 clk_ref edges after the first edge sampling the new clk_in level, high for 1 cycle.
REQ-018 Free-running counter cnt SHALL increment each cycle, saturating at all-ones; on each rise event cnt <= 1.
REQ-019 On each rise event except the first after reset/enable, period <= cnt and period_valid pulses on the same cycle as rise_pulse.
REQ-020 Good period: |period - EXPECT_PERIOD| <= TOL, computed in CNT_W+1 bits unsigned; saturated cnt is always bad.
REQ-021 IDLE -> ACQUIRE when enable is high; the first rise only arms measurement.
REQ-022 ACQUIRE: good period increments good_cnt; bad period clears it; good_cnt == LOCK_COUNT -> LOCKED on the next cycle.
REQ-023 LOCKED: bad period -> LOST; lost <= 1.
REQ-024 LOST: next rise event -> ACQUIRE with good_cnt = 0; lost stays high.
REQ-025 enable low SHALL force IDLE next cycle, clear cnt, good_cnt, lost, period and pulses; this overrides every other event in the same cycle.
REQ-026 A rise event coinciding with a timeout (REQ-030) SHALL take priority; the timeout is discarded.

Reset
REQ-027 rst_n low at a clk_ref edge: state=IDLE, all outputs 0, synchronizer/history flops 0, cnt=0, good_cnt=0.
REQ-028 Reset mid-operation SHALL abort any measurement; the first rise after release only re-arms.

Configuration
REQ-029 Macro CLK_LOCK_MONITOR_TIMEOUT_EN selects timeout detection.
REQ-030 Defined: in ACQUIRE or LOCKED, cnt reaching 2*EXPECT_PERIOD with no rise -> LOST (lost <= 1) and cnt <= 0; LOST from timeout exits per REQ-024.
REQ-031 Undefined: no timeout logic; a stalled clk_in holds the current state and cnt saturates.

Verification
REQ-032 clk_in toggling every 16 cycles, enable=1 -> period=32 strobes; locked=1 after 4 good periods (5th rise plus 1 cycle); lost=0.
REQ-033 Locked, one half-period stretched to 20 cycles (period 36) -> state LOST, lost=1, locked=0; after resume, relock after 4 more good periods, lost still 1.
REQ-034 Periods 33, 31, 33, 31 (within TOL=1) -> lock; period 34 during ACQUIRE -> good_cnt clears, lock delayed by 4 further good periods.
REQ-035 With TIMEOUT_EN, clk_in stuck low while locked -> LOST exactly 64 cycles after last rise event; without TIMEOUT_EN -> remains LOCKED, cnt saturates at 0xFFFF.
REQ-036 enable low for 1 cycle while locked (same cycle as a rise) -> IDLE, all outputs 0, lost cleared; relock requires arm plus 4 good periods.
REQ-037 rst_n low mid-ACQUIRE for 1 cycle -> outputs 0 next cycle; first rise after release gives no period_valid.
